// File: rtl/gray_step_pkg.sv
// Shared types, Gray conversion helpers and default sizing
// for the Gray-code step controller.
package gray_step_pkg;

    localparam int GS_WIDTH_DEF  = 3;
    localparam int GS_DIV_DEF    = 4;
    localparam int GS_SETTLE_DEF = 2;
    localparam int GS_MAXW       = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    function automatic logic [GS_MAXW-1:0] bin2gray(
        input logic [GS_MAXW-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GS_MAXW-1:0] gray2bin(
        input logic [GS_MAXW-1:0] g
    );
        logic [GS_MAXW-1:0] b;
        b[GS_MAXW-1] = g[GS_MAXW-1];
        for (int i = GS_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_core.sv
// Binary up/down position counter with a Gray copy registered
// on the same edge, so q never shows an intermediate code.
module gray_step_core
    import gray_step_pkg::*;
#(
    parameter int WIDTH = GS_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_step,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_pos,
    output logic [WIDTH-1:0] o_pos_adj,
    output logic [WIDTH-1:0] o_q
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_pos;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_pos_adj;

    // Neighbour position, independent of i_step to keep the
    // controller's step decision free of combinational loops.
    assign w_pos_adj = i_dir ? (r_pos - ONE) : (r_pos + ONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos <= '0;
            r_q   <= '0;
        end else if (i_step) begin
            r_pos <= w_pos_adj;
            r_q   <= WIDTH'(bin2gray(GS_MAXW'(w_pos_adj)));
        end
    end

    assign o_pos     = r_pos;
    assign o_pos_adj = w_pos_adj;
    assign o_q       = r_q;

endmodule

// File: rtl/gray_step_controller.sv
// Command FSM, step divider and settle timer for the Gray stepper.
// Define GRAY_STEP_SHORTEST_PATH_EN to allow downward moves.
module gray_step_controller
    import gray_step_pkg::*;
#(
    parameter int WIDTH  = GS_WIDTH_DEF,
    parameter int DIV    = GS_DIV_DEF,
    parameter int SETTLE = GS_SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             cmd_abort,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] pos,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] SET_LAST =
        SW'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [DW-1:0]    r_div;
    logic [SW-1:0]    r_set;
    logic [WIDTH-1:0] r_target;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_step;
    logic             w_dir_new;
    logic             w_div_last;
    logic             w_set_last;
    logic [WIDTH-1:0] w_pos;
    logic [WIDTH-1:0] w_pos_adj;
    logic [WIDTH-1:0] w_q;

`ifdef GRAY_STEP_SHORTEST_PATH_EN
    localparam logic [WIDTH:0] HALF = (WIDTH+1)'(1) << (WIDTH - 1);
    logic [WIDTH-1:0] w_up_dist;
    assign w_up_dist = cmd_target - w_pos;
    // Ties on the half-circle go up.
    assign w_dir_new = ({1'b0, w_up_dist} > HALF);
`else
    assign w_dir_new = 1'b0;
`endif

    assign w_div_last = (r_div == DIV_LAST);
    assign w_set_last = (r_set == SET_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (cmd_target == w_pos) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                if (cmd_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_div_last) begin
                    w_step = 1'b1;
                    if (w_pos_adj == r_target) begin
                        w_state_nxt = (SETTLE == 0) ? S_DONE : S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (cmd_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_set_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_set    <= '0;
            r_target <= '0;
            r_dir    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_STEP) ||
                       (w_state_nxt == S_SETTLE);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_target <= cmd_target;
                r_dir    <= w_dir_new;
            end
            if ((r_state == S_STEP) && !w_div_last) begin
                r_div <= r_div + DW'(1);
            end else begin
                r_div <= '0;
            end
            if (r_state == S_SETTLE) begin
                r_set <= r_set + SW'(1);
            end else begin
                r_set <= '0;
            end
        end
    end

    gray_step_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_step    (w_step),
        .i_dir     (r_dir),
        .o_pos     (w_pos),
        .o_pos_adj (w_pos_adj),
        .o_q       (w_q)
    );

    assign cmd_ready = (r_state == S_IDLE);
    assign q         = w_q;
    assign pos       = w_pos;
    assign dir       = r_dir;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_gray_step_controller.sv
// Directed bench for gray_step_controller, WIDTH=3 DIV=4 SETTLE=2.
// Expected codes come from a hand-written Gray table.
module tb_gray_step_controller;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_target;
    logic       cmd_abort;
    logic [2:0] q;
    logic [2:0] pos;
    logic       dir;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fail;

    logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};

    gray_step_controller #(
        .WIDTH  (3),
        .DIV    (4),
        .SETTLE (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_abort  (cmd_abort),
        .q          (q),
        .pos        (pos),
        .dir        (dir),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] t);
        cmd_valid  = 1'b1;
        cmd_target = t;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic move_to(input logic [2:0] t, output bit ok);
        ok = 1'b0;
        accept(t);
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (q !== 3'b000 || pos !== 3'd0 || dir !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state q=%b pos=%0d dir=%b busy=%b done=%b rdy=%b exp 000/0/0/0/0/1",
                     q, pos, dir, busy, done, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (q !== 3'b000 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release q=%b rdy=%b busy=%b exp 000/1/0",
                     q, cmd_ready, busy);
        end
    endtask

    task automatic test_up_0_to_5();
        logic [2:0] prev;
        int ip;
        accept(3'd5);
        n_checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || q !== 3'b000) begin
            n_fail++;
            $display("FAIL up_accept busy=%b rdy=%b q=%b exp 1/0/000",
                     busy, cmd_ready, q);
        end
        prev = q;
        for (int k = 1; k <= 23; k++) begin
            tick();
            ip = (k / 4 > 5) ? 5 : k / 4;
            n_checks++;
            if (q !== gtab[ip] || pos !== 3'(ip)) begin
                n_fail++;
                $display("FAIL up_q k=%0d q=%b pos=%0d exp q=%b pos=%0d",
                         k, q, pos, gtab[ip], ip);
            end
            n_checks++;
            if (done !== (k == 22) || busy !== (k < 22)) begin
                n_fail++;
                $display("FAIL up_flags k=%0d done=%b busy=%b exp %b/%b",
                         k, done, busy, (k == 22), (k < 22));
            end
            n_checks++;
            if ($countones(q ^ prev) > 1) begin
                n_fail++;
                $display("FAIL up_onebit k=%0d prev=%b q=%b exp <=1 bit change",
                         k, prev, q);
            end
            prev = q;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL up_ready rdy=%b exp 1", cmd_ready);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int seq [4] = '{6, 7, 0, 1};
        int ip;
        move_to(3'd6, ok);
        n_checks++;
        if (!ok || pos !== 3'd6) begin
            n_fail++;
            $display("FAIL wrap_setup ok=%0d pos=%0d exp 1/6", ok, pos);
        end
        accept(3'd1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            ip = (k / 4 > 3) ? 3 : k / 4;
            n_checks++;
            if (q !== gtab[seq[ip]] || pos !== 3'(seq[ip])) begin
                n_fail++;
                $display("FAIL wrap_q k=%0d q=%b pos=%0d exp q=%b pos=%0d",
                         k, q, pos, gtab[seq[ip]], seq[ip]);
            end
            n_checks++;
            if (done !== (k == 14) || busy !== (k < 14) ||
                (busy && dir !== 1'b0)) begin
                n_fail++;
                $display("FAIL wrap_flags k=%0d done=%b busy=%b dir=%b exp %b/%b/0",
                         k, done, busy, dir, (k == 14), (k < 14));
            end
        end
    endtask

    task automatic test_shortest();
        int seq [6];
        int nsteps;
        logic exp_dir;
        int ip;
        int kd;
`ifdef GRAY_STEP_SHORTEST_PATH_EN
        seq = '{1, 0, 7, 6, 6, 6};
        nsteps = 3;
        exp_dir = 1'b1;
`else
        seq = '{1, 2, 3, 4, 5, 6};
        nsteps = 5;
        exp_dir = 1'b0;
`endif
        kd = nsteps * 4 + 2;
        accept(3'd6);
        for (int k = 1; k <= kd + 1; k++) begin
            tick();
            ip = (k / 4 > nsteps) ? nsteps : k / 4;
            n_checks++;
            if (q !== gtab[seq[ip]] || pos !== 3'(seq[ip])) begin
                n_fail++;
                $display("FAIL short_q k=%0d q=%b pos=%0d exp q=%b pos=%0d",
                         k, q, pos, gtab[seq[ip]], seq[ip]);
            end
            n_checks++;
            if (done !== (k == kd) || busy !== (k < kd) ||
                (busy && dir !== exp_dir)) begin
                n_fail++;
                $display("FAIL short_flags k=%0d done=%b busy=%b dir=%b exp %b/%b/%b",
                         k, done, busy, dir, (k == kd), (k < kd), exp_dir);
            end
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL short_ready rdy=%b exp 1", cmd_ready);
        end
    endtask

    task automatic test_same_pos();
        bit ok;
        move_to(3'd3, ok);
        n_checks++;
        if (!ok || pos !== 3'd3 || q !== 3'b010) begin
            n_fail++;
            $display("FAIL same_setup ok=%0d pos=%0d q=%b exp 1/3/010",
                     ok, pos, q);
        end
        accept(3'd3);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 3'b010 ||
            cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL same_done done=%b busy=%b q=%b rdy=%b exp 1/0/010/0",
                     done, busy, q, cmd_ready);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 3'b010 ||
            cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL same_after done=%b busy=%b q=%b rdy=%b exp 0/0/010/1",
                     done, busy, q, cmd_ready);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit bad;
        move_to(3'd0, ok);
        n_checks++;
        if (!ok || pos !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_setup ok=%0d pos=%0d exp 1/0", ok, pos);
        end
        accept(3'd5);
        repeat (8) tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        n_checks++;
        if (pos !== 3'd2 || q !== 3'b011 || cmd_ready !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_hold pos=%0d q=%b rdy=%b busy=%b done=%b exp 2/011/1/0/0",
                     pos, q, cmd_ready, busy, done);
        end
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (done !== 1'b0 || pos !== 3'd2) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL abort_quiet done=%b pos=%0d exp 0/2", done, pos);
        end
    endtask

    task automatic test_back_to_back();
        accept(3'd3);
        tick();
        cmd_valid  = 1'b1;
        cmd_target = 3'd0;
        tick();
        cmd_valid  = 1'b0;
        tick();
        tick();
        n_checks++;
        if (pos !== 3'd3 || q !== 3'b010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_step pos=%0d q=%b busy=%b exp 3/010/1",
                     pos, q, busy);
        end
        tick();
        tick();
        n_checks++;
        if (done !== 1'b1 || pos !== 3'd3) begin
            n_fail++;
            $display("FAIL b2b_done done=%b pos=%0d exp 1/3", done, pos);
        end
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready rdy=%b done=%b exp 1/0", cmd_ready, done);
        end
        cmd_abort = 1'b1;
        accept(3'd4);
        cmd_abort = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_abort busy=%b rdy=%b exp 1/0",
                     busy, cmd_ready);
        end
        repeat (6) tick();
        n_checks++;
        if (done !== 1'b1 || pos !== 3'd4 || q !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_second done=%b pos=%0d q=%b exp 1/4/110",
                     done, pos, q);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit bad;
        accept(3'd0);
        repeat (6) tick();
        n_checks++;
        if (pos !== 3'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre pos=%0d busy=%b exp 5/1", pos, busy);
        end
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (q !== 3'b000 || pos !== 3'd0 || cmd_ready !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async q=%b pos=%0d rdy=%b busy=%b done=%b exp 000/0/1/0/0",
                     q, pos, cmd_ready, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (30) begin
            tick();
            if (done !== 1'b0 || pos !== 3'd0 || cmd_ready !== 1'b1) begin
                bad = 1'b1;
            end
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rmid_quiet done=%b pos=%0d rdy=%b exp 0/0/1",
                     done, pos, cmd_ready);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_target = 3'd0;
        cmd_abort  = 1'b0;
        test_reset();
        test_up_0_to_5();
        test_wrap();
        test_shortest();
        test_same_pos();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_step_controller.md
# gray_step_controller

Sequencer for a Gray-code position counter. Accepts a target position over a valid/ready command interface and walks a registered Gray-code output one code per step interval until it reaches the target. After a settle window it pulses `done`. It sits between a command source (CPU/FSM) and any logic consuming the glitch-free Gray position `q`, such as encoders, async-crossing pointers or stepper phase drivers.

## Interface
- `WIDTH`, default 3: position width; positions 0..2^WIDTH-1.
- `DIV`, default 4: clock cycles per step, ≥1.
- `SETTLE`, default 2: cycles held at target before `done`, ≥0.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_target`  in  WIDTH  binary target index, sampled on accept.
- `cmd_abort`  in  1  stop motion at the current position.
- `q`  out  WIDTH  registered Gray code of `pos`.
- `pos`  out  WIDTH  registered binary position.
- `dir`  out  1  0 = up, 1 = down; valid while busy.
- `busy`  out  1  high in STEP and SETTLE.
- `done`  out  1  one-cycle pulse on completion.

## Operation
- States: IDLE, STEP, SETTLE, DONE.
- IDLE:
  - `cmd_ready=1`. Accept on `cmd_valid & cmd_ready`; latch the target and compute the direction.
  - If target == `pos`, go to DONE; otherwise go to STEP and clear the divider.
- STEP:
  - The divider counts 0..DIV-1. On the edge where the divider == DIV-1, `pos` moves ±1 modulo 2^WIDTH and `q` updates on the same edge. Exactly one bit of `q` changes per step.
  - When the new `pos` equals the target, go to SETTLE (or to DONE if SETTLE=0).
- SETTLE: count SETTLE cycles, then go to DONE.
- DONE: `done=1` for one cycle, then go to IDLE.
- Direction: always up (wrap 2^WIDTH-1→0). Distance is (target−pos) mod 2^WIDTH.
- Abort:
  - `cmd_abort` in STEP or SETTLE → IDLE on the next edge. `pos` and `q` hold, and no `done` is issued.
  - Ignored in IDLE and DONE.
  - Abort has priority over a step on the same edge: no step occurs.
- `cmd_valid` while not IDLE is ignored. No queueing.
- Reset (asynchronous, active-low) forces: state IDLE, `pos=0`, `q=0`, `dir=0`, `busy=0`, `done=0`, `cmd_ready=1`. Reset mid-move abandons the move with no `done`.

## Timing
- Let the accept edge be E0 and the distance d.
- Step k occurs at E0+k·DIV.
- `done` is high in the cycle following edge E0+d·DIV+SETTLE (the DONE state).
- `cmd_ready` is high again one cycle after `done`.
- d=0: DONE is entered at E0, so `done` is high in the cycle after accept.
- All outputs are registered except `cmd_ready`, which is decoded from the state register.
- `busy` deasserts on entry to DONE.

## Configuration
- `GRAY_STEP_SHORTEST_PATH_EN`
  - Defined: with u = (target−pos) mod 2^WIDTH, move up if u ≤ 2^(WIDTH-1), else move down with distance 2^WIDTH−u. A tie goes up.
  - Undefined: always move up, and `dir` is tied to 0.

## Structure
- Package `gray_step_pkg`:
  - state enum
  - `bin2gray` / `gray2bin` functions
  - default constants for WIDTH/DIV/SETTLE
- Sub-module `gray_step_core`:
  - binary up/down counter with step-enable and direction inputs
  - registered `bin2gray` output
  - asynchronous active-low reset
- `gray_step_controller` holds the FSM, divider, settle counter and direction logic.

## Test plan
All scenarios use WIDTH=3, DIV=4, SETTLE=2.
- Reset, then target 5 from 0 (macro off) → `q` = 000,001,011,010,110,111 at E0+4,8,12,16,20; `done` high in the cycle after edge E0+22; one bit changes per step.
- Wrap from `pos`=6 to target 1 (either config) → `q` = 101,100,000,001; 3 steps; `dir`=0.
- With macro, `pos`=1 to target 6 → `dir`=1; `q` = 001,000,100,101; `done` in the cycle after edge E0+14. With macro off the same command takes 5 steps up.
- Target equals `pos` (3) → `done` in the cycle after accept; `q` stays 010; `busy` never rises.
- `cmd_abort` asserted at E0+9 on a 0→5 move → `pos`=2, `q`=011 hold; `cmd_ready`=1 next cycle; no `done`. A new `cmd_valid` during STEP is ignored.
- Drop `rst` low mid-move, between clock edges → `q`=000, `pos`=0 and `cmd_ready`=1 immediately; no `done` after release.
